// File: rtl/regfile_pkg.sv
// Shared definitions for the 2-read/1-write register file.
// Holds the default geometry and the clear-engine state type.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_ADDR_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Sequential bulk-clear engine for the register file.
// A clear_req in IDLE starts a sweep that zeroes one entry per cycle, in order 0..DEPTH-1.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear_req    single-cycle request to start a clear (ignored while busy)
//   busy         high while the sweep runs
//   clear_done   one-cycle pulse after the last entry is zeroed
//   clr_we       array write strobe for the zeroing write
//   clr_addr     entry being zeroed this cycle
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  // Depth is always 2**ADDR_W, so the last entry is the all-ones address.
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        // Pointer wraps back to 0 naturally after the last entry.
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == CLEAR);
  assign clr_we     = busy;
  assign clr_addr   = ptr_q;
  assign clear_done = done_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised register file: one synchronous write port, two registered read ports,
// optional hard-wired zero entry and a sequential bulk-clear engine.
// Optional macro REGFILE_BYPASS_EN: forward same-edge write data to a read port whose
// address matches the write address (otherwise reads return the pre-write value).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   write_enable/rw/busw write strobe, address, data (dropped while busy)
//   ra/rb -> busa/busb   read addresses and their registered data (1-cycle latency)
//   clear_req            start a bulk clear; busy/clear_done report its progress
module reg_file_2r1w
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] rw,
  input  logic [DATA_W-1:0] busw,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] busa,
  output logic [DATA_W-1:0] busb,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_zero_blk;
  logic              usr_we;
  logic [DATA_W-1:0] rd_a, rd_b;

  regfile_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_done (clear_done),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr)
  );

  // Writes are only accepted in IDLE; anything arriving during a sweep is discarded.
  assign wr_zero_blk = (ZERO_REG != 0) && (rw == '0);
  assign usr_we      = write_enable && !busy && !wr_zero_blk;

  always_comb begin
    rd_a = mem[ra];
    rd_b = mem[rb];
`ifdef REGFILE_BYPASS_EN
    // usr_we already excludes the zero entry, so forwarding never leaks into it.
    if (usr_we && (ra == rw)) rd_a = busw;
    if (usr_we && (rb == rw)) rd_b = busw;
`endif
    if ((ZERO_REG != 0) && (ra == '0)) rd_a = '0;
    if ((ZERO_REG != 0) && (rb == '0)) rd_b = '0;
  end

  // clr_we and usr_we are mutually exclusive (usr_we needs !busy), so priority is moot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (usr_we) begin
      mem[rw] <= busw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busa <= '0;
      busb <= '0;
    end else begin
      busa <= rd_a;
      busb <= rd_b;
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: two instances (ZERO_REG=0 and ZERO_REG=1) share
// one stimulus stream and are compared every cycle against a behavioural array model.
module tb_reg_file_2r1w;

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned N  = 16;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          write_enable;
  logic          clear_req;
  logic [AW-1:0] rw, ra, rb;
  logic [DW-1:0] busw;
  logic [DW-1:0] busa [2];
  logic [DW-1:0] busb [2];
  logic          busy [2];
  logic          clear_done [2];

  always #5 clk = ~clk;

  reg_file_2r1w #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .ZERO_REG (0)
  ) u_dut0 (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .rw           (rw),
    .busw         (busw),
    .ra           (ra),
    .rb           (rb),
    .busa         (busa[0]),
    .busb         (busb[0]),
    .clear_req    (clear_req),
    .busy         (busy[0]),
    .clear_done   (clear_done[0])
  );

  reg_file_2r1w #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .ZERO_REG (1)
  ) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .rw           (rw),
    .busw         (busw),
    .ra           (ra),
    .rb           (rb),
    .busa         (busa[1]),
    .busb         (busb[1]),
    .clear_req    (clear_req),
    .busy         (busy[1]),
    .clear_done   (clear_done[1])
  );

  // Reference model: plain arrays plus a count of entries already swept.
  logic [DW-1:0] mm [2][N];
  logic [DW-1:0] ma [2];
  logic [DW-1:0] mb [2];
  bit            m_active;
  bit            m_done;
  int            m_cnt;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < N; j++) mm[i][j] = '0;
      ma[i] = '0;
      mb[i] = '0;
    end
    m_active = 1'b0;
    m_done   = 1'b0;
    m_cnt    = 0;
  endtask

  // Applies the rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic [DW-1:0] old [2][N];
    bit            zr, fwd;
    if (rst) begin
      model_reset();
      return;
    end
    old = mm;
    for (int i = 0; i < 2; i++) begin
      zr  = (i == 1);
      fwd = BYP && !m_active && write_enable && !(zr && rw == 0);
      ma[i] = (zr && ra == 0) ? '0 : (fwd && ra == rw) ? busw : old[i][ra];
      mb[i] = (zr && rb == 0) ? '0 : (fwd && rb == rw) ? busw : old[i][rb];
      if (m_active) mm[i][m_cnt] = '0;
      else if (write_enable && !(zr && rw == 0)) mm[i][rw] = busw;
    end
    if (m_active) begin
      m_cnt++;
      m_done = (m_cnt == N);
      if (m_done) m_active = 1'b0;
    end else begin
      m_done = 1'b0;
      if (clear_req) begin
        m_active = 1'b1;
        m_cnt    = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("busa%0d", i), 32'(busa[i]), 32'(ma[i]));
      check($sformatf("busb%0d", i), 32'(busb[i]), 32'(mb[i]));
      check($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_active));
      check($sformatf("done%0d", i), 32'(clear_done[i]), 32'(m_done));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Issues a clear (with a same-edge write that must be wiped), attempts a write mid-sweep,
  // and counts busy samples and done pulses, bounded so a stuck engine cannot hang the run.
  task automatic run_clear(output int busy_cycles, output int dones);
    clear_req    = 1'b1;
    write_enable = 1'b1;
    rw           = 4'd9;
    busw         = 4'hC;
    step();
    clear_req   = 1'b0;
    busy_cycles = busy[0] ? 1 : 0;
    dones       = clear_done[0] ? 1 : 0;
    for (int k = 0; k < 40 && dones == 0; k++) begin
      write_enable = (k == 3);
      rw           = 4'd15;
      busw         = 4'h7;
      ra           = 4'(k);
      rb           = 4'(N - 1 - k);
      step();
      if (busy[0]) busy_cycles++;
      if (clear_done[0]) dones++;
    end
    write_enable = 1'b0;
    repeat (3) begin
      step();
      if (clear_done[0]) dones++;
    end
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] rw;
    logic [DW-1:0] busw;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    bit            chk;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic [DW-1:0] eza;
  } vec_t;

  function automatic vec_t mk(bit we, logic [AW-1:0] w, logic [DW-1:0] d, logic [AW-1:0] a,
                              logic [AW-1:0] b, bit c, logic [DW-1:0] ea, logic [DW-1:0] eb,
                              logic [DW-1:0] eza);
    vec_t v;
    v.we = we; v.rw = w; v.busw = d; v.ra = a; v.rb = b;
    v.chk = c; v.ea = ea; v.eb = eb; v.eza = eza;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [11];
    int   bc, dn;

    tbl[0]  = mk(0, 0, 4'h0, 3, 15, 1, 4'h0, 4'h0, 4'h0);
    tbl[1]  = mk(1, 4, 4'hA, 0, 0,  1, 4'h0, 4'h0, 4'h0);
    tbl[2]  = mk(1, 7, 4'h8, 0, 0,  0, 4'h0, 4'h0, 4'h0);
    tbl[3]  = mk(0, 0, 4'h0, 4, 7,  1, 4'hA, 4'h8, 4'hA);
    tbl[4]  = mk(1, 5, 4'h1, 0, 0,  0, 4'h0, 4'h0, 4'h0);
    tbl[5]  = mk(1, 5, 4'h3, 5, 4,  1, BYP ? 4'h3 : 4'h1, 4'hA, BYP ? 4'h3 : 4'h1);
    tbl[6]  = mk(0, 0, 4'h0, 5, 5,  1, 4'h3, 4'h3, 4'h3);
    tbl[7]  = mk(1, 0, 4'hF, 1, 2,  1, 4'h0, 4'h0, 4'h0);
    tbl[8]  = mk(0, 0, 4'h0, 0, 0,  1, 4'hF, 4'hF, 4'h0);
    tbl[9]  = mk(1, 0, 4'h6, 0, 0,  1, BYP ? 4'h6 : 4'hF, BYP ? 4'h6 : 4'hF, 4'h0);
    tbl[10] = mk(0, 0, 4'h0, 0, 0,  1, 4'h6, 4'h6, 4'h0);

    // Reset state is visible before any clock edge.
    rst = 1'b1; write_enable = 1'b0; clear_req = 1'b0;
    rw = '0; ra = '0; rb = '0; busw = '0;
    model_reset();
    #1;
    compare_all();
    step();
    step();
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 11; i++) begin
      write_enable = tbl[i].we;
      rw           = tbl[i].rw;
      busw         = tbl[i].busw;
      ra           = tbl[i].ra;
      rb           = tbl[i].rb;
      step();
      if (tbl[i].chk) begin
        check($sformatf("vec%0d_a", i), 32'(busa[0]), 32'(tbl[i].ea));
        check($sformatf("vec%0d_b", i), 32'(busb[0]), 32'(tbl[i].eb));
        check($sformatf("vec%0d_za", i), 32'(busa[1]), 32'(tbl[i].eza));
      end
    end
    write_enable = 1'b0;

    // Bulk clear over a file filled with 5s.
    for (int i = 0; i < N; i++) begin
      write_enable = 1'b1;
      rw   = 4'(i);
      busw = 4'h5;
      step();
    end
    run_clear(bc, dn);
    check("clr_busy_cycles", 32'(bc), 32'(N));
    check("clr_done_pulses", 32'(dn), 32'd1);
    for (int i = 0; i < N; i++) begin
      ra = 4'(i);
      rb = 4'(N - 1 - i);
      step();
      check("clr_rd_a", 32'(busa[0]), 32'd0);
      check("clr_rd_b", 32'(busb[0]), 32'd0);
    end

    // Reset in the middle of a clear.
    for (int i = 0; i < N; i++) begin
      write_enable = 1'b1;
      rw   = 4'(i);
      busw = 4'(i + 1);
      step();
    end
    write_enable = 1'b0;
    clear_req    = 1'b1;
    step();
    clear_req = 1'b0;
    dn = 0;
    repeat (6) begin
      step();
      if (clear_done[0]) dn++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("rstmid_busy", 32'(busy[0]), 32'd0);
    compare_all();
    step();
    if (clear_done[0]) dn++;
    step();
    if (clear_done[0]) dn++;
    rst = 1'b0;
    check("rstmid_no_done", 32'(dn), 32'd0);
    for (int i = 0; i < N; i++) begin
      ra = 4'(i);
      rb = 4'(i);
      step();
      check("rstmid_rd", 32'(busa[0]), 32'd0);
    end
    run_clear(bc, dn);
    check("reclr_busy_cycles", 32'(bc), 32'(N));
    check("reclr_done_pulses", 32'(dn), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      write_enable = 1'($urandom_range(0, 1));
      rw           = 4'($urandom_range(0, N - 1));
      busw         = 4'($urandom_range(0, 15));
      ra           = ($urandom_range(0, 3) == 0) ? rw : 4'($urandom_range(0, N - 1));
      rb           = 4'($urandom_range(0, N - 1));
      clear_req    = ($urandom_range(0, 39) == 0);
      step();
    end
    write_enable = 1'b0;
    clear_req    = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
